mem_rd_stream: RTL and testbench
================================

Name: mem_rd_stream

Overview:
- Read-side sequencer for the team's simple dual-port block memory (1-cycle registered read port: enB/addrB in, doutB out).
- On a start command it walks a programmable address range and emits each word as a valid/ready stream beat, with a last-beat flag.
- Absorbs the memory's read latency and downstream backpressure with a 2-entry output buffer. It sits directly downstream of the memory and feeds the compute datapath.

Parameters:
- WIDTH, 32, data word width; equals the memory WIDTH.
- DEPTH, 512, memory depth. AW = $clog2(DEPTH); LW = AW+1.

Ports:
- clkA  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle command strobe; accepted only when busy=0.
- base_addr  in  AW  first word address; sampled on accepted start.
- length  in  LW  beat count, 0..DEPTH; sampled on accepted start.
- busy  out  1  high from accepted start until final beat handshake/done.
- done  out  1  one-cycle pulse on completion.
- enB  out  1  memory read enable.
- addrB  out  AW  memory read address.
- doutB  in  WIDTH  memory read data; valid the cycle after an enB cycle.
- m_tdata  out  WIDTH  stream data.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tlast  out  1  high on the final beat of a command.

Behaviour:
- Reset: busy=0, done=0, enB=0, addrB=0, m_tvalid=0, m_tlast=0, m_tdata=0. Counters and buffer are emptied. Any in-flight read result is discarded.
- FSM states:
  - IDLE -> RUN on start with length>0.
  - IDLE -> ZERO on start with length=0. ZERO -> IDLE next cycle with done=1; no beats emitted.
  - RUN -> DRAIN when the final read has been issued.
  - DRAIN -> IDLE on the final beat handshake (m_tvalid & m_tready & m_tlast). done pulses in the cycle after that handshake; busy falls at the same edge.
- start while busy=1 is ignored. Its base_addr and length are not sampled.
- Read issue:
  - enB=1 for exactly one cycle per word; reads are never speculative or repeated.
  - Issue rule: issue in a cycle iff state=RUN and (buffer occupancy + reads in flight − pop this cycle) < 2.
  - addrB starts at base_addr and increments by 1 per issued read, modulo DEPTH (DEPTH-1 wraps to 0).
- Buffer:
  - doutB is written into the 2-entry FIFO in the cycle after the enB cycle.
  - m_tdata/m_tvalid come from the FIFO head.
  - m_tdata is held stable while m_tvalid=1 and m_tready=0.
- Latency:
  - Start sampled at edge E0; first enB during the following cycle.
  - First m_tvalid=1 no later than the third edge after E0.
  - With m_tready held high, throughput is 1 beat/cycle with no bubbles after the first beat.
- m_tlast is asserted only on beat index length−1. Beat order equals address order.
- The buffer never overflows under arbitrary m_tready patterns, and no beats are lost or duplicated.
- rst asserted mid-command aborts immediately. There is no done pulse, and m_tvalid=0 in the next cycle.

Optional Feature:
- Macro MEM_RD_STREAM_STRIDE_EN.
- Defined:
  - Adds input port stride (AW bits), sampled on accepted start.
  - Address increments by stride per read, modulo DEPTH. stride=0 rereads base_addr length times.
- Undefined:
  - No stride port; increment fixed at 1.
  - All other behaviour is identical in both builds.

Test Plan:
- Basic run: mem[i]=i+100; base_addr=10, length=4, m_tready=1 -> beats 110,111,112,113 on consecutive cycles; m_tlast on 113 only; done pulse once; busy low afterwards; exactly 4 enB cycles.
- Backpressure: base 0, length 16, m_tready random at 50%, plus a 10-cycle stall mid-burst -> data 100..115 in order, no loss or duplicates, m_tdata stable during stalls, never more than 2 reads outstanding beyond the buffer.
- Wrap and full range:
  - base_addr=510, length=4 -> addresses 510,511,0,1.
  - base_addr=0, length=512 -> 512 beats; m_tlast on beat 511.
- Zero length and ignored start: length=0 -> no enB, no m_tvalid, done pulses once. A second start while busy -> ignored, and the original beat count is unchanged.
- Reset mid-op: rst during beat 3 of a length-8 run -> next cycle m_tvalid=0, busy=0, no done. A new start (base 20, length 2) afterwards -> beats 120,121 only; no stale data.
- MEM_RD_STREAM_STRIDE_EN: base 5, stride 3, length 4 -> addresses 5,8,11,14. Stride 0 -> 4 beats, all 105.

Source files
------------

// File: rtl/mem_rd_stream.sv
// Read-side sequencer: walks an address range on the block-RAM read port and streams words out.
// Optional MEM_RD_STREAM_STRIDE_EN adds a per-command address stride input.
module mem_rd_stream #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clkA,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [LW-1:0]    length,
`ifdef MEM_RD_STREAM_STRIDE_EN
  input  logic [AW-1:0]    stride,
`endif
  output logic             busy,
  output logic             done,
  output logic             enB,
  output logic [AW-1:0]    addrB,
  input  logic [WIDTH-1:0] doutB,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_ZERO} state_t;

  localparam logic [LW-1:0] DEPTH_W = LW'(DEPTH);

  state_t           state, state_nxt;
  logic [AW-1:0]    addr, step, step_in;
  logic [LW-1:0]    reads_left, beats_left;
  logic [LW-1:0]    addr_sum, addr_wrap;
  logic             rd_pend;
  logic [WIDTH-1:0] fifo [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       count;
  logic [2:0]       occ;
  logic             accept, pop, issue, last_hs;

`ifdef MEM_RD_STREAM_STRIDE_EN
  assign step_in = stride;
`else
  assign step_in = AW'(1);
`endif

  assign accept   = start && (state == S_IDLE);
  assign m_tvalid = (count != 2'd0);
  assign m_tdata  = fifo[rd_ptr];
  assign m_tlast  = m_tvalid && (beats_left == LW'(1));
  assign pop      = m_tvalid && m_tready;
  assign last_hs  = pop && m_tlast;
  assign busy     = (state != S_IDLE);

  // Words buffered plus the one possibly in flight must leave room for the new read.
  assign occ   = {1'b0, count} + {2'b00, rd_pend} - {2'b00, pop};
  assign issue = (state == S_RUN) && (occ < 3'd2) && (reads_left != '0);
  assign enB   = issue;
  assign addrB = addr;

  assign addr_sum  = {1'b0, addr} + {1'b0, step};
  assign addr_wrap = (addr_sum >= DEPTH_W) ? (addr_sum - DEPTH_W) : addr_sum;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = (length == '0) ? S_ZERO : S_RUN;
      S_RUN:   if (issue && (reads_left == LW'(1))) state_nxt = S_DRAIN;
      S_DRAIN: if (last_hs) state_nxt = S_IDLE;
      S_ZERO:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clkA) begin
    if (rst) begin
      state      <= S_IDLE;
      done       <= 1'b0;
      addr       <= '0;
      step       <= '0;
      reads_left <= '0;
      beats_left <= '0;
      rd_pend    <= 1'b0;
      fifo[0]    <= '0;
      fifo[1]    <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
    end else begin
      state   <= state_nxt;
      done    <= ((state == S_DRAIN) && last_hs) || (accept && (length == '0));
      rd_pend <= issue;
      if (accept) begin
        addr       <= base_addr;
        step       <= step_in;
        reads_left <= length;
        beats_left <= length;
      end else begin
        if (issue) begin
          addr       <= AW'(addr_wrap);
          reads_left <= reads_left - LW'(1);
        end
        if (pop) beats_left <= beats_left - LW'(1);
      end
      if (rd_pend) begin
        fifo[wr_ptr] <= doutB;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, rd_pend} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_mem_rd_stream.sv
// Directed bench for mem_rd_stream: table of commands plus hand-written reset/abort sequence.
// Stride vectors are added when MEM_RD_STREAM_STRIDE_EN is defined.
module tb_mem_rd_stream;
  localparam int WIDTH = 32;
  localparam int DEPTH = 512;
  localparam int AW = 9;
  localparam int LW = 10;

  logic             clkA = 1'b0;
  logic             rst, start;
  logic [AW-1:0]    base_addr;
  logic [LW-1:0]    length;
`ifdef MEM_RD_STREAM_STRIDE_EN
  logic [AW-1:0]    stride;
`endif
  logic             busy, done, enB;
  logic [AW-1:0]    addrB;
  logic [WIDTH-1:0] doutB;
  logic [WIDTH-1:0] m_tdata;
  logic             m_tvalid, m_tready, m_tlast;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] mem [DEPTH];

  always #5 clkA = ~clkA;

  always @(posedge clkA) if (enB) doutB <= mem[addrB];

  mem_rd_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clkA(clkA), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
`ifdef MEM_RD_STREAM_STRIDE_EN
    .stride(stride),
`endif
    .busy(busy), .done(done), .enB(enB), .addrB(addrB), .doutB(doutB),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast)
  );

  typedef struct {
    string name;
    int    base;
    int    len;
    int    stride;
    int    mode;      // 0: ready high, 1: random with 10-cycle stall, 2: random
    bit    restart;   // pulse a second start while busy
    int    exp_first;
    int    exp_last;
  } vec_t;

  vec_t vecs[$];

  function automatic void chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  task automatic run_cmd(input vec_t v);
    int cyc, nbeat, n_en, n_done, first_v, last_hs_c, done_c, issued, accepted, budget, step;
    bit ovf, stall_bad, order_bad, last_bad, addr_bad, busy_bad, prev_stall;
    logic [WIDTH-1:0] prev_data, first_data, last_data;
    int exp_a;
    nbeat = 0; n_en = 0; n_done = 0; first_v = -1; last_hs_c = -1; done_c = -1;
    issued = 0; accepted = 0; ovf = 0; stall_bad = 0; order_bad = 0; last_bad = 0;
    addr_bad = 0; busy_bad = 0; prev_stall = 0; prev_data = '0; first_data = '0; last_data = '0;
`ifdef MEM_RD_STREAM_STRIDE_EN
    step = v.stride;
`else
    step = 1;
`endif
    budget = v.len * 4 + 60;
    @(negedge clkA);
    start = 1'b1;
    base_addr = AW'(v.base);
    length = LW'(v.len);
`ifdef MEM_RD_STREAM_STRIDE_EN
    stride = AW'(v.stride);
`endif
    m_tready = 1'b1;
    for (cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clkA);
      start = 1'b0;
      if (v.restart && cyc == 2) begin
        start = 1'b1;
        base_addr = AW'(200);
        length = LW'(8);
      end
      case (v.mode)
        0: m_tready = 1'b1;
        1: m_tready = (cyc >= 8 && cyc < 18) ? 1'b0 : 1'($urandom_range(0, 1));
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (enB) begin
        exp_a = (v.base + n_en * step) % DEPTH;
        if (int'(addrB) != exp_a) addr_bad = 1;
        n_en++;
        issued++;
      end
      if (m_tvalid && first_v < 0) first_v = cyc;
      if (prev_stall && (!m_tvalid || m_tdata != prev_data)) stall_bad = 1;
      if (m_tvalid && m_tready) begin
        exp_a = (v.base + nbeat * step) % DEPTH;
        if (m_tdata != WIDTH'(exp_a + 100)) order_bad = 1;
        if (m_tlast != (nbeat == v.len - 1)) last_bad = 1;
        if (nbeat == 0) first_data = m_tdata;
        last_data = m_tdata;
        if (m_tlast) last_hs_c = cyc;
        nbeat++;
        accepted++;
      end
      if (issued - accepted > 2) ovf = 1;
      prev_stall = m_tvalid && !m_tready;
      prev_data = m_tdata;
      if (done) begin
        n_done++;
        if (done_c < 0) done_c = cyc;
        if (v.len > 0 && busy) busy_bad = 1;
      end
      if (done_c > 0 && cyc == done_c + 3) break;
    end
    m_tready = 1'b1;
    chk({v.name, "/timeout"}, (done_c > 0), 1);
    chk({v.name, "/beats"}, nbeat, v.len);
    chk({v.name, "/enb_cnt"}, n_en, v.len);
    chk({v.name, "/done_cnt"}, n_done, 1);
    chk({v.name, "/busy_end"}, busy, 0);
    if (v.len > 0) begin
      chk({v.name, "/first_data"}, first_data, v.exp_first);
      chk({v.name, "/last_data"}, last_data, v.exp_last);
      chk({v.name, "/order"}, order_bad, 0);
      chk({v.name, "/tlast"}, last_bad, 0);
      chk({v.name, "/addr"}, addr_bad, 0);
      chk({v.name, "/stall_hold"}, stall_bad, 0);
      chk({v.name, "/outstanding"}, ovf, 0);
      chk({v.name, "/busy_at_done"}, busy_bad, 0);
      chk({v.name, "/done_timing"}, done_c, last_hs_c + 1);
      chk({v.name, "/first_valid_le3"}, (first_v > 0 && first_v <= 3), 1);
      if (v.mode == 0) chk({v.name, "/no_bubble"}, last_hs_c - first_v, v.len - 1);
    end else begin
      chk({v.name, "/done_cyc"}, done_c, 1);
      chk({v.name, "/no_valid"}, first_v, -1);
    end
  endtask

  initial begin
    int beats_seen, cyc;
    bit hit, done_bad;
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i + 100);
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_tready = 1'b0;
`ifdef MEM_RD_STREAM_STRIDE_EN
    stride = '0;
`endif
    repeat (3) @(negedge clkA);
    #1;
    chk("rst/busy", busy, 0);
    chk("rst/done", done, 0);
    chk("rst/enB", enB, 0);
    chk("rst/addrB", addrB, 0);
    chk("rst/tvalid", m_tvalid, 0);
    chk("rst/tlast", m_tlast, 0);
    chk("rst/tdata", m_tdata, 0);
    rst = 1'b0;

    vecs.push_back('{"basic",   10,   4, 1, 0, 1'b0, 110, 113});
    vecs.push_back('{"bkpr",     0,  16, 1, 1, 1'b0, 100, 115});
    vecs.push_back('{"wrap",   510,   4, 1, 0, 1'b0, 610, 101});
    vecs.push_back('{"full",     0, 512, 1, 0, 1'b0, 100, 611});
    vecs.push_back('{"rand3",   20,   3, 1, 2, 1'b0, 120, 122});
    vecs.push_back('{"single", 300,   1, 1, 2, 1'b0, 400, 400});
    vecs.push_back('{"ignore",  10,   4, 1, 1, 1'b1, 110, 113});
    vecs.push_back('{"zero",     7,   0, 1, 0, 1'b0,   0,   0});
`ifdef MEM_RD_STREAM_STRIDE_EN
    vecs.push_back('{"stride3",  5,   4, 3, 0, 1'b0, 105, 114});
    vecs.push_back('{"stride0",  5,   4, 0, 2, 1'b0, 105, 105});
    vecs.push_back('{"strwrap", 500,  3, 10, 0, 1'b0, 600, 108});
`endif
    foreach (vecs[i]) run_cmd(vecs[i]);

    // Abort: reset while beat 3 of a length-8 run is presented.
    @(negedge clkA);
    start = 1'b1; base_addr = '0; length = LW'(8); m_tready = 1'b1;
    beats_seen = 0; hit = 0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clkA);
      start = 1'b0;
      #1;
      if (m_tvalid) begin
        if (beats_seen == 3) begin
          rst = 1'b1;
          hit = 1;
          break;
        end
        beats_seen++;
      end
    end
    chk("abort/reached_beat3", hit, 1);
    @(negedge clkA);
    #1;
    chk("abort/tvalid", m_tvalid, 0);
    chk("abort/busy", busy, 0);
    chk("abort/done", done, 0);
    chk("abort/enB", enB, 0);
    rst = 1'b0;
    done_bad = 0;
    repeat (5) begin
      @(negedge clkA);
      #1;
      if (done || m_tvalid || enB) done_bad = 1;
    end
    chk("abort/quiet_after", done_bad, 0);
    run_cmd('{"post_abort", 20, 2, 1, 0, 1'b0, 120, 121});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
